lockin_udp_packetizer: RTL and testbench
========================================

Name: lockin_udp_packetizer

Overview:
- Read-side consumer of the lock-in result FIFO (108-bit words, written in the ADC domain, read in the UDP domain).
- Drains lock-in records and serializes each one into 32-bit words.
- Frames the records into packets with a header and a trailer, and presents them on a valid/ready stream to the UDP transmitter.
- Closes a packet when it is full, when the FIFO stays idle past a timeout, or on a flush request.

Parameters:
- MAX_RECORDS, 32: records per packet before a forced close; range 1..255.
- TIMEOUT_CYCLES, 1250: empty-FIFO cycles, with at least 1 record in the packet, before the packet is closed.
- HDR_MAGIC, 16'h4C4B: upper half of the header word.
- TRL_MAGIC, 16'h454E: upper half of the trailer word.

Ports:
- clk_udp  in  1  UDP-domain clock; all logic runs on this clock.
- reset_n  in  1  synchronous, active-low reset.
- fifo_q  in  108  FIFO read data; non-show-ahead, valid 1 cycle after fifo_rdreq. Bits [103:0] = {idx[7:0], freq[31:0], Y[31:0], X[31:0]}; bits [107:104] are ignored.
- fifo_rdempty  in  1  FIFO empty flag.
- fifo_rdreq  out  1  FIFO read strobe; single-cycle pulses.
- flush_req  in  1  pulse: close the current packet after the record in progress.
- tx_data  out  32  stream data.
- tx_valid  out  1  stream valid.
- tx_sop  out  1  first word of a packet (the header).
- tx_eop  out  1  last word of a packet (the trailer).
- tx_ready  in  1  downstream accept.
- seq_num  out  16  sequence number of the next packet to be sent.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - fifo_rdreq, tx_valid, tx_sop, tx_eop, busy = 0.
  - tx_data, seq_num, record counter, timeout counter = 0.
  - State = IDLE.
  - Reset in the middle of a packet abandons that packet with no trailer; a record already popped is lost.
- Transfer rule: a word transfers on a cycle with tx_valid && tx_ready. While tx_valid=1 and tx_ready=0, tx_data, tx_sop and tx_eop hold stable. tx_valid never drops without a transfer.
- FIFO rule: fifo_rdreq is asserted only when fifo_rdempty=0 in the same cycle; it is never high on consecutive cycles.
- States:
  - IDLE: if fifo_rdempty=0, go to HDR. flush_req is ignored in IDLE; empty packets are never sent.
  - HDR: tx_data={HDR_MAGIC, seq_num}, tx_sop=1. On transfer, go to FETCH.
  - FETCH: assert fifo_rdreq for 1 cycle (FIFO is guaranteed non-empty on entry), go to LATCH.
  - LATCH: capture fifo_q into the holding register, go to W0.
  - W0..W3: send the record as 4 words, advancing one state per transfer:
    - W0 = {24'd0, idx}
    - W1 = X
    - W2 = Y
    - W3 = freq
  - End of W3 transfer: increment nrec. Then:
    - if nrec (new value) == MAX_RECORDS, or a flush is pending: go to TRL;
    - else if fifo_rdempty=0: go to FETCH;
    - else go to WAITR with the timeout counter cleared.
  - WAITR: timeout counter increments each cycle.
    - fifo_rdempty=0: go to FETCH (counter cleared).
    - flush pending, or counter == TIMEOUT_CYCLES-1: go to TRL.
    - If both conditions occur in the same cycle, TRL wins.
  - TRL: tx_data={TRL_MAGIC, 8'd0, nrec}, tx_eop=1. On transfer: seq_num increments (wraps 16'hFFFF to 0), nrec=0, flush pending cleared, go to IDLE.
- Flush: a flush_req pulse seen in any state except IDLE sets the flush-pending flag; the flag is cleared only in TRL.
- Throughput: 6 cycles per record with tx_ready held high (FETCH, LATCH, W0..W3).
- Latency: fifo_rdempty falls in IDLE at cycle t → header valid at t+1. Back-to-back packets have 1 IDLE cycle between trailer and next header.

Test Plan:
- Single record: FIFO holds idx=8'h05, X=32'h11111111, Y=32'h22222222, freq=32'h33333333; tx_ready=1. Stream must be 4C4B0000, 00000005, 11111111, 22222222, 33333333, then TRL 454E0001 after TIMEOUT_CYCLES empty cycles; seq_num becomes 1.
- Full packet: 40 records preloaded, MAX_RECORDS=32. Packet 0 has 32 records and trailer 454E0020. Packet 1 (header 4C4B0001) has 8 records and trailer 454E0008.
- Backpressure: tx_ready toggles at random (~50%). All words must stay stable while stalled, no record is lost or duplicated, and fifo_rdreq count equals the number of records sent.
- Flush: pulse flush_req while W1 of the 3rd record is waiting. The trailer must follow W3 with count 3, and no further fifo_rdreq may be issued in that packet.
- Timeout race: FIFO goes non-empty on the exact cycle the timeout counter reaches TIMEOUT_CYCLES-1. TRL must be sent, and the record must appear in the next packet.
- Reset mid-packet: drive reset_n=0 during W2. Next cycle all outputs must be 0; after reset the next header must be 4C4B0000.

Source files
------------

// File: rtl/lockin_udp_packetizer.sv
// Drains 108-bit lock-in records from the result FIFO and frames them into header/record/trailer
// packets of 32-bit words on a valid/ready stream toward the UDP transmitter.
module lockin_udp_packetizer #(
  parameter int unsigned MAX_RECORDS    = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1250,
  parameter logic [15:0] HDR_MAGIC      = 16'h4C4B,
  parameter logic [15:0] TRL_MAGIC      = 16'h454E
) (
  input  logic         clk_udp,
  input  logic         reset_n,
  input  logic [107:0] fifo_q,
  input  logic         fifo_rdempty,
  output logic         fifo_rdreq,
  input  logic         flush_req,
  output logic [31:0]  tx_data,
  output logic         tx_valid,
  output logic         tx_sop,
  output logic         tx_eop,
  input  logic         tx_ready,
  output logic [15:0]  seq_num,
  output logic         busy
);

  localparam int unsigned TcntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TcntW-1:0] TcntLast = TcntW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] MaxRec = 8'(MAX_RECORDS);

  localparam logic [3:0] StIdle  = 4'd0;
  localparam logic [3:0] StHdr   = 4'd1;
  localparam logic [3:0] StFetch = 4'd2;
  localparam logic [3:0] StLatch = 4'd3;
  localparam logic [3:0] StW0    = 4'd4;
  localparam logic [3:0] StW1    = 4'd5;
  localparam logic [3:0] StW2    = 4'd6;
  localparam logic [3:0] StW3    = 4'd7;
  localparam logic [3:0] StWaitr = 4'd8;
  localparam logic [3:0] StTrl   = 4'd9;

  logic [3:0]       state_q, state_d;
  logic [15:0]      seq_q, seq_d;
  logic [7:0]       nrec_q, nrec_d;
  logic [TcntW-1:0] tcnt_q, tcnt_d;
  logic             flush_q, flush_d;
  logic [103:0]     rec_q, rec_d;
  logic             flush_pend;
  logic [7:0]       nrec_inc;

  // Tag nibble of the FIFO word carries nothing for the packet format.
  logic unused_fifo_tag;
  assign unused_fifo_tag = ^fifo_q[107:104];

  assign flush_pend = flush_q | flush_req;
  assign nrec_inc   = nrec_q + 8'd1;

  always_comb begin
    state_d = state_q;
    seq_d   = seq_q;
    nrec_d  = nrec_q;
    tcnt_d  = tcnt_q;
    rec_d   = rec_q;
    flush_d = flush_q | (flush_req && (state_q != StIdle));
    unique case (state_q)
      StIdle:  if (!fifo_rdempty) state_d = StHdr;
      StHdr:   if (tx_ready) state_d = StFetch;
      StFetch: if (!fifo_rdempty) state_d = StLatch;
      StLatch: begin
        rec_d   = fifo_q[103:0];
        state_d = StW0;
      end
      StW0:    if (tx_ready) state_d = StW1;
      StW1:    if (tx_ready) state_d = StW2;
      StW2:    if (tx_ready) state_d = StW3;
      StW3: begin
        if (tx_ready) begin
          nrec_d = nrec_inc;
          if ((nrec_inc == MaxRec) || flush_pend) begin
            state_d = StTrl;
          end else if (!fifo_rdempty) begin
            state_d = StFetch;
          end else begin
            state_d = StWaitr;
            tcnt_d  = '0;
          end
        end
      end
      StWaitr: begin
        // Closing takes priority over a record arriving on the final timeout cycle.
        if (flush_pend || (tcnt_q == TcntLast)) begin
          state_d = StTrl;
        end else if (!fifo_rdempty) begin
          state_d = StFetch;
          tcnt_d  = '0;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      StTrl: begin
        if (tx_ready) begin
          seq_d   = seq_q + 16'd1;
          nrec_d  = '0;
          flush_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_udp) begin
    if (!reset_n) begin
      state_q <= StIdle;
      seq_q   <= '0;
      nrec_q  <= '0;
      tcnt_q  <= '0;
      flush_q <= 1'b0;
      rec_q   <= '0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      nrec_q  <= nrec_d;
      tcnt_q  <= tcnt_d;
      flush_q <= flush_d;
      rec_q   <= rec_d;
    end
  end

  always_comb begin
    tx_data  = '0;
    tx_valid = 1'b0;
    tx_sop   = 1'b0;
    tx_eop   = 1'b0;
    unique case (state_q)
      StHdr: begin
        tx_data  = {HDR_MAGIC, seq_q};
        tx_valid = 1'b1;
        tx_sop   = 1'b1;
      end
      StW0: begin
        tx_data  = {24'd0, rec_q[103:96]};
        tx_valid = 1'b1;
      end
      StW1: begin
        tx_data  = rec_q[31:0];
        tx_valid = 1'b1;
      end
      StW2: begin
        tx_data  = rec_q[63:32];
        tx_valid = 1'b1;
      end
      StW3: begin
        tx_data  = rec_q[95:64];
        tx_valid = 1'b1;
      end
      StTrl: begin
        tx_data  = {TRL_MAGIC, 8'd0, nrec_q};
        tx_valid = 1'b1;
        tx_eop   = 1'b1;
      end
      default: ;
    endcase
  end

  assign fifo_rdreq = (state_q == StFetch) && !fifo_rdempty;
  assign seq_num    = seq_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_lockin_udp_packetizer.sv
// Bench for lockin_udp_packetizer: FIFO model, stream collector and a packet-level reference model.
module tb_lockin_udp_packetizer;

  localparam int unsigned MaxRec = 32;
  localparam int unsigned To     = 1250;

  logic         clk_udp = 1'b0;
  logic         reset_n = 1'b0;
  logic [107:0] fifo_q = '0;
  logic         fifo_rdempty = 1'b1;
  logic         fifo_rdreq;
  logic         flush_req = 1'b0;
  logic [31:0]  tx_data;
  logic         tx_valid, tx_sop, tx_eop;
  logic         tx_ready = 1'b1;
  logic [15:0]  seq_num;
  logic         busy;

  lockin_udp_packetizer #(
    .MAX_RECORDS   (MaxRec),
    .TIMEOUT_CYCLES(To),
    .HDR_MAGIC     (16'h4C4B),
    .TRL_MAGIC     (16'h454E)
  ) dut (
    .clk_udp     (clk_udp),
    .reset_n     (reset_n),
    .fifo_q      (fifo_q),
    .fifo_rdempty(fifo_rdempty),
    .fifo_rdreq  (fifo_rdreq),
    .flush_req   (flush_req),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_sop      (tx_sop),
    .tx_eop      (tx_eop),
    .tx_ready    (tx_ready),
    .seq_num     (seq_num),
    .busy        (busy)
  );

  always #5 clk_udp = ~clk_udp;

  typedef struct { logic [33:0] w; int stamp; } rx_t;

  int           checks = 0;
  int           passed = 0;
  int           cyc = 0;
  int           rdcnt = 0;
  int           rdy_mode = 0;  // 0: always ready, 1: random, 2: driven by the test
  logic [107:0] fq[$];
  logic [103:0] sent[$];
  logic [33:0]  exp_q[$];
  rx_t          rx[$];
  logic         do_pop = 1'b0;
  logic         prev_rd = 1'b0;
  logic         stall_prev = 1'b0;
  logic [33:0]  held = '0;

  // FIFO model: rdreq seen before an edge pops at that edge, data valid the cycle after.
  always @(negedge clk_udp) begin
    do_pop = (fifo_rdreq === 1'b1);
    if (reset_n && do_pop) begin
      rdcnt++;
      checks++;
      if (fifo_rdempty || prev_rd) $display("FAIL fifo_rule: rdreq with empty=%0b prev_rdreq=%0b, required 0/0", fifo_rdempty, prev_rd);
      else passed++;
    end
    prev_rd = do_pop;
  end

  always @(posedge clk_udp) begin
    cyc++;
    if (do_pop && fq.size() > 0) begin
      fifo_q <= fq.pop_front();
      fifo_rdempty <= (fq.size() == 0);
    end
  end

  always @(posedge clk_udp) begin
    #1;
    if (rdy_mode == 0) tx_ready = 1'b1;
    else if (rdy_mode == 1) tx_ready = 1'($urandom_range(0, 1));
  end

  always @(negedge clk_udp) begin
    if (reset_n && tx_valid === 1'b1 && tx_ready) rx.push_back('{w: {tx_sop, tx_eop, tx_data}, stamp: cyc});
  end

  always @(negedge clk_udp) begin
    if (!reset_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        checks++;
        if (tx_valid !== 1'b1 || {tx_sop, tx_eop, tx_data} !== held)
          $display("FAIL stall_hold: got v=%0b %h, required v=1 %h", tx_valid, {tx_sop, tx_eop, tx_data}, held);
        else passed++;
      end
      stall_prev = (tx_valid === 1'b1) && !tx_ready;
      held = {tx_sop, tx_eop, tx_data};
    end
  end

  // Reference packet: header, four words per record (idx, X, Y, freq), trailer with record count.
  function automatic void model_pkt(input logic [15:0] seq, input int first, input int n);
    logic [103:0] r;
    exp_q.push_back({2'b10, 16'h4C4B, seq});
    for (int i = first; i < first + n; i++) begin
      r = sent[i];
      exp_q.push_back({2'b00, 24'd0, r[103:96]});
      exp_q.push_back({2'b00, r[31:0]});
      exp_q.push_back({2'b00, r[63:32]});
      exp_q.push_back({2'b00, r[95:64]});
    end
    exp_q.push_back({2'b01, 16'h454E, 8'd0, 8'(n)});
  endfunction

  task automatic push_rec(input logic [103:0] r);
    fq.push_back({4'($urandom), r});
    sent.push_back(r);
    fifo_rdempty = 1'b0;
  endtask

  function automatic logic [103:0] rand_rec();
    return {8'($urandom), $urandom, $urandom, $urandom};
  endfunction

  task automatic wait_rx(input int n, input int budget);
    int k = 0;
    while (rx.size() < n && k < budget) begin
      @(negedge clk_udp);
      #1;
      k++;
    end
  endtask

  task automatic do_reset();
    @(posedge clk_udp);
    #1;
    reset_n = 1'b0;
    flush_req = 1'b0;
    rdy_mode = 0;
    tx_ready = 1'b1;
    fq.delete();
    sent.delete();
    rx.delete();
    exp_q.delete();
    fifo_rdempty = 1'b1;
    repeat (3) @(posedge clk_udp);
    #1;
    rdcnt = 0;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk_udp);
    #1;
    checks++;
    if ({fifo_rdreq, tx_valid, tx_sop, tx_eop, busy, tx_data, seq_num} !== 53'd0)
      $display("FAIL reset_outputs: got rd=%0b v=%0b sop=%0b eop=%0b busy=%0b data=%h seq=%h, required all 0",
               fifo_rdreq, tx_valid, tx_sop, tx_eop, busy, tx_data, seq_num);
    else passed++;
  endtask

  task automatic test_single();
    int push_cyc;
    do_reset();
    push_cyc = cyc;
    push_rec({8'h05, 32'h33333333, 32'h22222222, 32'h11111111});
    wait_rx(6, To + 100);
    checks++;
    if (rx.size() !== 6) $display("FAIL single_count: got %0d words, required 6", rx.size());
    else passed++;
    model_pkt(16'd0, 0, 1);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= rx.size() || rx[i].w !== exp_q[i])
        $display("FAIL single_word[%0d]: got %h, required %h", i, (i < rx.size()) ? rx[i].w : 34'h0, exp_q[i]);
      else passed++;
    end
    if (rx.size() == 6) begin
      checks++;
      if (rx[0].stamp - push_cyc != 1) $display("FAIL hdr_latency: got %0d, required 1", rx[0].stamp - push_cyc);
      else passed++;
      checks++;
      if (rx[5].stamp - rx[4].stamp != To + 1)
        $display("FAIL timeout_gap: got %0d, required %0d", rx[5].stamp - rx[4].stamp, To + 1);
      else passed++;
    end
    @(posedge clk_udp);
    #1;
    checks++;
    if (seq_num !== 16'd1) $display("FAIL single_seq: got %h, required 0001", seq_num);
    else passed++;
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 40; i++) push_rec(rand_rec());
    wait_rx(164, 40 * 6 + To + 200);
    model_pkt(16'd0, 0, 32);
    model_pkt(16'd1, 32, 8);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= rx.size() || rx[i].w !== exp_q[i])
        $display("FAIL full_word[%0d]: got %h, required %h", i, (i < rx.size()) ? rx[i].w : 34'h0, exp_q[i]);
      else passed++;
    end
    checks++;
    if (rdcnt !== 40) $display("FAIL full_rdcnt: got %0d, required 40", rdcnt);
    else passed++;
    if (rx.size() >= 164) begin
      checks++;
      if (rx[8].stamp - rx[4].stamp != 6) $display("FAIL throughput: got %0d, required 6", rx[8].stamp - rx[4].stamp);
      else passed++;
      checks++;
      if (rx[130].stamp - rx[129].stamp != 2) $display("FAIL pkt_gap: got %0d, required 2", rx[130].stamp - rx[129].stamp);
      else passed++;
    end
  endtask

  task automatic test_back_to_back_backpressure();
    do_reset();
    rdy_mode = 1;
    for (int i = 0; i < 20; i++) push_rec(rand_rec());
    wait_rx(82, 20 * 20 + To + 500);
    model_pkt(16'd0, 0, 20);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= rx.size() || rx[i].w !== exp_q[i])
        $display("FAIL bp_word[%0d]: got %h, required %h", i, (i < rx.size()) ? rx[i].w : 34'h0, exp_q[i]);
      else passed++;
    end
    checks++;
    if (rdcnt !== 20) $display("FAIL bp_rdcnt: got %0d, required 20", rdcnt);
    else passed++;
    @(posedge clk_udp);
    #1;
    checks++;
    if (seq_num !== 16'd1) $display("FAIL bp_seq: got %h, required 0001", seq_num);
    else passed++;
    rdy_mode = 0;
  endtask

  task automatic test_flush();
    do_reset();
    rdy_mode = 2;
    tx_ready = 1'b1;
    for (int i = 0; i < 5; i++) push_rec(rand_rec());
    wait_rx(10, 200);
    @(posedge clk_udp);
    #1;
    tx_ready = 1'b0;
    flush_req = 1'b1;
    checks++;
    if (tx_data !== sent[2][31:0]) $display("FAIL flush_w1: got %h, required %h", tx_data, sent[2][31:0]);
    else passed++;
    @(posedge clk_udp);
    #1;
    flush_req = 1'b0;
    repeat (3) @(posedge clk_udp);
    #1;
    tx_ready = 1'b1;
    wait_rx(14, 200);
    checks++;
    if (rdcnt !== 3) $display("FAIL flush_rdcnt: got %0d, required 3", rdcnt);
    else passed++;
    wait_rx(24, To + 200);
    model_pkt(16'd0, 0, 3);
    model_pkt(16'd1, 3, 2);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= rx.size() || rx[i].w !== exp_q[i])
        $display("FAIL flush_word[%0d]: got %h, required %h", i, (i < rx.size()) ? rx[i].w : 34'h0, exp_q[i]);
      else passed++;
    end
    rdy_mode = 0;
  endtask

  task automatic test_timeout_race();
    int s;
    do_reset();
    push_rec(rand_rec());
    wait_rx(5, 100);
    s = (rx.size() >= 5) ? rx[4].stamp : cyc;
    repeat (To) @(posedge clk_udp);
    #1;
    push_rec(rand_rec());
    wait_rx(12, To + 200);
    model_pkt(16'd0, 0, 1);
    model_pkt(16'd1, 1, 1);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= rx.size() || rx[i].w !== exp_q[i])
        $display("FAIL race_word[%0d]: got %h, required %h", i, (i < rx.size()) ? rx[i].w : 34'h0, exp_q[i]);
      else passed++;
    end
    if (rx.size() >= 6) begin
      checks++;
      if (rx[5].stamp != s + To + 1) $display("FAIL race_trl_time: got %0d, required %0d", rx[5].stamp, s + To + 1);
      else passed++;
    end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    for (int i = 0; i < 3; i++) push_rec(rand_rec());
    wait_rx(3, 100);
    @(posedge clk_udp);
    #1;
    checks++;
    if (tx_data !== sent[0][63:32]) $display("FAIL mid_w2: got %h, required %h", tx_data, sent[0][63:32]);
    else passed++;
    reset_n = 1'b0;
    @(posedge clk_udp);
    #1;
    checks++;
    if ({fifo_rdreq, tx_valid, tx_sop, tx_eop, busy, tx_data, seq_num} !== 53'd0)
      $display("FAIL mid_reset_outputs: got v=%0b busy=%0b data=%h seq=%h, required all 0",
               tx_valid, busy, tx_data, seq_num);
    else passed++;
    rx.delete();
    @(posedge clk_udp);
    #1;
    reset_n = 1'b1;
    wait_rx(10, To + 200);
    model_pkt(16'd0, 1, 2);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= rx.size() || rx[i].w !== exp_q[i])
        $display("FAIL mid_word[%0d]: got %h, required %h", i, (i < rx.size()) ? rx[i].w : 34'h0, exp_q[i]);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_back_to_back_backpressure();
    test_flush();
    test_timeout_race();
    test_reset_mid_packet();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
